// File: rtl/analyzer_capture_write_fsm_pkg.sv
// Shared analyzer definitions: buffer sizing, capture FSM state codes, index wrap helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package analyzer_capture_write_fsm_pkg;

    // Capture FSM state encoding, kept as plain constants so older readers can decode dumps.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRETRIG  = 3'd1;
    localparam logic [2:0] ST_ARMED    = 3'd2;
    localparam logic [2:0] ST_POSTTRIG = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Highest packet index held by the circular buffer; the readback side uses the same figure.
    function automatic logic [31:0] max_sample_number(input int capacity,
                                                      input int word_width,
                                                      input int packet_width);
        int words_per_packet;
        words_per_packet = packet_width / 8 / word_width;
        return 32'(capacity / word_width / words_per_packet - 1);
    endfunction

    // Next packet index, folding back to 0 after the last slot.
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] max_idx);
        return (idx >= max_idx) ? 32'd0 : idx + 32'd1;
    endfunction

    // Index that lies n slots before idx on the ring.
    function automatic logic [31:0] wrap_sub(input logic [31:0] idx, input logic [31:0] n,
                                             input logic [31:0] max_idx);
        return (idx >= n) ? idx - n : idx + max_idx + 32'd1 - n;
    endfunction

endpackage

// File: rtl/analyzer_capture_write_fsm_capture_index_counter.sv
// Wrapping packet index counter with synchronous load and advance enable.
// Latency: new value visible the cycle after load/enable.
// Backpressure: none; caller gates enable with accepted writes only.
module capture_index_counter
    import analyzer_capture_write_fsm_pkg::*;
#(
    parameter logic [31:0] MAX_VALUE = 32'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        enable,
    output logic [31:0] index
);

    // Load wins over advance so a new capture always starts from a clean index.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= 32'd0;
        end else if (load) begin
            index <= load_value;
        end else if (enable) begin
            index <= wrap_inc(index, MAX_VALUE);
        end
    end

endmodule

// File: rtl/analyzer_capture_write_fsm.sv
// Capture-side write sequencer: pretrigger fill, trigger capture, posttrigger count into a ring.
// Latency: write_req combinational from sample_valid; index/status registered, one cycle.
// Backpressure: write_allowed low drops the sample, holds the index and sets sticky overflow.
module analyzer_capture_write_fsm
    import analyzer_capture_write_fsm_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = 32,
    parameter int MEMORY_CAPACITY     = 2**27,
    parameter int MEMORY_WORD_WIDTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] pretrigger_count,
    input  logic [31:0] posttrigger_count,
    input  logic        sample_valid,
    input  logic        trigger_hit,
    input  logic        write_allowed,
    output logic        write_req,
    output logic [31:0] writeSampleNumber,
    output logic        idle,
    output logic        triggered,
    output logic        overflow,
    output logic        config_err,
    output logic [31:0] sampleNumber_Begin,
    output logic [31:0] sampleNumber_End
);

    localparam logic [31:0] MAX_SAMPLE_NUMBER =
        max_sample_number(MEMORY_CAPACITY, MEMORY_WORD_WIDTH, SAMPLE_PACKET_WIDTH);

    logic [2:0]  state;
    logic [31:0] pre_lat;
    logic [31:0] post_lat;
    logic [31:0] phase_cnt;
    logic        in_capture;
    logic        acc;
    logic        arm;
    logic        cfg_bad;

    // Request path is purely state-decoded so the memory port sees it in the same cycle.
    always_comb begin
        in_capture = (state == ST_PRETRIG) || (state == ST_ARMED) || (state == ST_POSTTRIG);
        write_req  = in_capture && sample_valid;
        acc        = write_req && write_allowed;
        idle       = (state == ST_IDLE) || (state == ST_DONE);
        arm        = idle && start && !abort;
        cfg_bad    = ({2'b00, pretrigger_count} + {2'b00, posttrigger_count} + 34'd1)
                     > {2'b00, MAX_SAMPLE_NUMBER};
    end

    capture_index_counter #(
        .MAX_VALUE (MAX_SAMPLE_NUMBER)
    ) u_index (
        .clk        (clk),
        .reset      (reset),
        .load       (arm),
        .load_value (32'd0),
        .enable     (acc),
        .index      (writeSampleNumber)
    );

    // Capture sequencing, sticky status and the published Begin/End window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_IDLE;
            pre_lat            <= 32'd0;
            post_lat           <= 32'd0;
            phase_cnt          <= 32'd0;
            triggered          <= 1'b0;
            overflow           <= 1'b0;
            config_err         <= 1'b0;
            sampleNumber_Begin <= 32'd0;
            sampleNumber_End   <= 32'd0;
        end else begin
            if (in_capture && sample_valid && !write_allowed) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        pre_lat    <= pretrigger_count;
                        post_lat   <= posttrigger_count;
                        phase_cnt  <= 32'd0;
                        triggered  <= 1'b0;
                        overflow   <= 1'b0;
                        config_err <= cfg_bad;
                        if (cfg_bad) begin
                            state <= ST_IDLE;
                        end else if (pretrigger_count == 32'd0) begin
                            state <= ST_ARMED;
                        end else begin
                            state <= ST_PRETRIG;
                        end
                    end
                end
                ST_PRETRIG: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (acc) begin
                        if (phase_cnt + 32'd1 == pre_lat) begin
                            phase_cnt <= 32'd0;
                            state     <= ST_ARMED;
                        end else begin
                            phase_cnt <= phase_cnt + 32'd1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (acc && trigger_hit) begin
                        triggered          <= 1'b1;
                        sampleNumber_Begin <= wrap_sub(writeSampleNumber, pre_lat, MAX_SAMPLE_NUMBER);
                        phase_cnt          <= 32'd0;
                        if (post_lat == 32'd0) begin
                            sampleNumber_End <= wrap_inc(writeSampleNumber, MAX_SAMPLE_NUMBER);
                            state            <= ST_DONE;
                        end else begin
                            state <= ST_POSTTRIG;
                        end
                    end
                end
                ST_POSTTRIG: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (acc) begin
                        if (phase_cnt + 32'd1 == post_lat) begin
                            sampleNumber_End <= wrap_inc(writeSampleNumber, MAX_SAMPLE_NUMBER);
                            state            <= ST_DONE;
                        end else begin
                            phase_cnt <= phase_cnt + 32'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/analyzer_capture_write_fsm.md
# analyzer_capture_write_fsm

Capture-side write sequencer for the logic analyzer sample memory. It issues one write request per accepted sample packet into a circular packet buffer and enforces pretrigger fill, trigger detection and posttrigger count. On completion it publishes `sampleNumber_Begin` / `sampleNumber_End` and `idle` to the readback sequencer. It sits between the sampler/trigger logic and the memory interface write port.

## Interface
**Parameters**
- `SAMPLE_PACKET_WIDTH`, default 32: bits per stored packet.
- `MEMORY_CAPACITY`, default 2**27: memory size in bytes.
- `MEMORY_WORD_WIDTH`, default 2: bytes per memory word.
- Derived: `MAX_SAMPLE_NUMBER = MEMORY_CAPACITY/MEMORY_WORD_WIDTH/(SAMPLE_PACKET_WIDTH/8/MEMORY_WORD_WIDTH) - 1`.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: arm capture. Honoured only in IDLE or DONE.
- `abort`, in, 1: cancel capture, return to IDLE.
- `pretrigger_count`, in, 32: packets required before the trigger. Latched on start.
- `posttrigger_count`, in, 32: packets stored after the trigger packet. Latched on start.
- `sample_valid`, in, 1: a new packet is available this cycle.
- `trigger_hit`, in, 1: the current packet satisfies the trigger condition.
- `write_allowed`, in, 1: the memory interface accepts a write this cycle.
- `write_req`, out, 1: write request (combinational).
- `writeSampleNumber`, out, 32: packet index for the current write.
- `idle`, out, 1: capture is not running (state IDLE or DONE).
- `triggered`, out, 1: sticky; trigger was accepted in this capture.
- `overflow`, out, 1: sticky; a packet was dropped because `write_allowed` was low.
- `config_err`, out, 1: sticky; the latched counts do not fit in the buffer.
- `sampleNumber_Begin`, out, 32: index of the first valid packet.
- `sampleNumber_End`, out, 32: exclusive end index.

## Operation
- States: IDLE, PRETRIG, ARMED, POSTTRIG, DONE.
- An accepted write (acc) is `write_req & write_allowed`. `write_req = sample_valid` in PRETRIG, ARMED and POSTTRIG; otherwise 0.
- **IDLE / DONE + start:**
  - Latch both counts.
  - Clear `triggered`, `overflow`, `config_err` and the internal counters.
  - Set `writeSampleNumber` to 0.
  - If `pretrigger_count + posttrigger_count + 1 > MAX_SAMPLE_NUMBER`, set `config_err` and go to IDLE.
  - Otherwise, if `pretrigger_count == 0`, go to ARMED; else go to PRETRIG.
- **PRETRIG:**
  - Count accepted writes. `trigger_hit` is ignored in this state.
  - When the count reaches `pretrigger_count`, go to ARMED.
- **ARMED:**
  - Circular writes.
  - On acc with `trigger_hit`: store trigger index T, set `triggered`, and compute Begin = wrap(T - pretrigger_count).
  - Then go to POSTTRIG, or to DONE if `posttrigger_count == 0`.
  - A `trigger_hit` on a non-accepted cycle is ignored.
- **POSTTRIG:**
  - Count accepted writes.
  - When the count reaches `posttrigger_count`, go to DONE.
  - End = the index following the last written packet.
- **Index advance:** on each acc, `writeSampleNumber` increments. `MAX_SAMPLE_NUMBER` wraps to 0.
- **Begin subtraction:** if T >= pre, Begin = T - pre; else Begin = T + MAX_SAMPLE_NUMBER + 1 - pre. All arithmetic is 32-bit unsigned.
- **Drop:** `sample_valid & !write_allowed` in a capture state sets `overflow`. The index and counters hold and the sample is lost.
- **abort:** in any capture state, go to IDLE next cycle. Begin and End keep their previous values. abort has priority over start and over the trigger.
- **DONE:** holds until start or reset.

## Timing
- `write_req` is combinational from state and `sample_valid`.
- `writeSampleNumber` is registered and advances the cycle after acc.
- `sampleNumber_Begin` updates the cycle after the trigger acc.
- `sampleNumber_End` updates the cycle DONE is entered. Begin and End are stable whenever `idle` = 1.
- `idle`, `triggered`, `overflow` and `config_err` are registered or state-decoded, one-cycle latency.
- Reset values: state IDLE; `idle` = 1; every other output = 0.
- Reset mid-capture: IDLE the next cycle; Begin and End are cleared to 0.

## Structure
- Shared analyzer package holds:
  - the `MAX_SAMPLE_NUMBER` derivation, shared with the readback sequencer;
  - the state encoding constants;
  - the wrap-increment and wrap-subtract functions.
- One natural sub-module: `capture_index_counter`, a wrapping packet index with enable and load.

## Test plan
Bench parameters: `MEMORY_CAPACITY`=64, `MEMORY_WORD_WIDTH`=2, `SAMPLE_PACKET_WIDTH`=32, giving `MAX_SAMPLE_NUMBER`=15.
- **Basic capture:** pre=2, post=3, `write_allowed`=1, trigger on accepted packet index 4 -> Begin=2, End=8, `triggered`=1, `idle`=1 in DONE, exactly 8 writes.
- **Wrap-around:** pre=4, post=2, trigger on the 19th accepted packet (index 2 after wrap) -> Begin=14, End=5, and the index sequence shows 15->0.
- **Pretrigger masking:** pre=3, `trigger_hit` on indices 0–2, then on index 6 -> trigger accepted at 6, Begin=3.
- **Back-pressure:** `sample_valid`=1 with `write_allowed`=0 for 3 cycles in ARMED -> `overflow`=1 and `writeSampleNumber` held; writes resume with no index skip.
- **Abort:** abort in POSTTRIG after a prior capture with Begin=2/End=8 -> IDLE next cycle, `write_req`=0, Begin/End remain 2/8.
- **Config error:** pre=10, post=10 -> `config_err`=1, state stays IDLE, no write_req.
